// File: rtl/svo_term_writer_if.sv
// ---------------------------------------------------------------------------
// svo_term_writer_if
// Bundles the character-input stream, the text RAM write channel and the
// cursor/scroll status of the SVO terminal writer.
//   in_tvalid/in_tready/in_tdata    8-bit character stream into the writer
//   mem_wvalid/mem_wready           text RAM write handshake
//   mem_waddr/mem_wdata             physical RAM address and character
//   top_row                         physical row shown as screen row 0
//   cur_x/cur_y                     cursor column / screen row
//   busy                            line or screen clear in progress
// modport master: the writer itself; modport slave: its environment.
// ---------------------------------------------------------------------------
interface svo_term_writer_if #(
   parameter int unsigned ADDR_BITS = 12
);
   logic                 in_tvalid;
   logic                 in_tready;
   logic [7:0]           in_tdata;
   logic                 mem_wvalid;
   logic                 mem_wready;
   logic [ADDR_BITS-1:0] mem_waddr;
   logic [7:0]           mem_wdata;
   logic [7:0]           top_row;
   logic [7:0]           cur_x;
   logic [7:0]           cur_y;
   logic                 busy;

   modport master (
      input  in_tvalid, in_tdata, mem_wready,
      output in_tready, mem_wvalid, mem_waddr, mem_wdata,
             top_row, cur_x, cur_y, busy
   );

   modport slave (
      output in_tvalid, in_tdata, mem_wready,
      input  in_tready, mem_wvalid, mem_waddr, mem_wdata,
             top_row, cur_x, cur_y, busy
   );
endinterface

// File: rtl/svo_term_writer.sv
// ---------------------------------------------------------------------------
// svo_term_writer
// Write-side terminal controller for the SVO text path. Consumes characters,
// keeps cursor and ring-buffer scroll offset, and sequences character writes
// and space-clears into the text RAM.
//   clk     single clock
//   resetn  asynchronous active-low reset; a full screen clear follows release
//   bus     svo_term_writer_if.master (char stream, RAM writes, status)
// ---------------------------------------------------------------------------
module svo_term_writer #(
   parameter int unsigned COLS      = 80,
   parameter int unsigned ROWS      = 30,
   parameter int unsigned ADDR_BITS = 12
) (
   input  logic               clk,
   input  logic               resetn,
   svo_term_writer_if.master  bus
);

   typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_SCR} state_t;

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(COLS*ROWS-1);
   localparam logic [7:0]           LAST_COL  = 8'(COLS-1);
   localparam logic [7:0]           LAST_ROW  = 8'(ROWS-1);
   localparam logic [7:0]           SPACE     = 8'h20;

   state_t               state_q;
   logic [7:0]           cx_q, cy_q, top_q, col_q;
   logic                 adv_q;
   logic                 wvalid_q, busy_q;
   logic [ADDR_BITS-1:0] waddr_q;
   logic [7:0]           wdata_q;

   logic [8:0]           row_sum;
   logic [7:0]           phys_row, top_inc;
   logic [ADDR_BITS-1:0] row_base, cur_addr, bs_addr, top_base;

   // Ring-buffer row mapping: top_q+cy_q < 2*ROWS, so one conditional
   // subtract is enough for the modulo.
   always_comb begin
      row_sum  = {1'b0, top_q} + {1'b0, cy_q};
      phys_row = (row_sum >= 9'(ROWS)) ? 8'(row_sum - 9'(ROWS)) : row_sum[7:0];
      row_base = ADDR_BITS'(phys_row) * ADDR_BITS'(COLS);
      cur_addr = row_base + ADDR_BITS'(cx_q);
      bs_addr  = cur_addr - ADDR_BITS'(1);
      top_inc  = (top_q == LAST_ROW) ? '0 : top_q + 8'd1;
      top_base = ADDR_BITS'(top_q) * ADDR_BITS'(COLS);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= CLR_SCR;
         cx_q     <= '0;
         cy_q     <= '0;
         top_q    <= '0;
         col_q    <= '0;
         adv_q    <= 1'b0;
         wvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_tvalid) begin
                  if (bus.in_tdata >= 8'h20 && bus.in_tdata <= 8'h7E) begin
                     state_q  <= WRITE;
                     wvalid_q <= 1'b1;
                     waddr_q  <= cur_addr;
                     wdata_q  <= bus.in_tdata;
                     adv_q    <= 1'b1;
                  end else begin
                     case (bus.in_tdata)
                        8'h0D: cx_q <= '0;
                        8'h0A: begin
                           cx_q <= '0;
                           if (cy_q != LAST_ROW) begin
                              cy_q <= cy_q + 8'd1;
                           end else begin
                              // New top is old top+1, so the old top physical
                              // row becomes screen row ROWS-1 and gets cleared.
                              top_q    <= top_inc;
                              state_q  <= CLR_LINE;
                              busy_q   <= 1'b1;
                              col_q    <= '0;
                              wvalid_q <= 1'b1;
                              waddr_q  <= top_base;
                              wdata_q  <= SPACE;
                           end
                        end
                        8'h08: begin
                           if (cx_q != '0) begin
                              cx_q     <= cx_q - 8'd1;
                              state_q  <= WRITE;
                              wvalid_q <= 1'b1;
                              waddr_q  <= bs_addr;
                              wdata_q  <= SPACE;
                              adv_q    <= 1'b0;
                           end
                        end
                        8'h0C: begin
                           cx_q     <= '0;
                           cy_q     <= '0;
                           top_q    <= '0;
                           state_q  <= CLR_SCR;
                           busy_q   <= 1'b1;
                           wvalid_q <= 1'b1;
                           waddr_q  <= '0;
                           wdata_q  <= SPACE;
                        end
                        default: ;
                     endcase
                  end
               end
            end

            WRITE: begin
               if (bus.mem_wready) begin
                  state_q  <= IDLE;
                  wvalid_q <= 1'b0;
                  if (adv_q) begin
                     if (cx_q != LAST_COL) begin
                        cx_q <= cx_q + 8'd1;
                     end else begin
                        // Auto-wrap: same newline/scroll as an LF, chained
                        // straight into the line clear without an IDLE gap.
                        cx_q <= '0;
                        if (cy_q != LAST_ROW) begin
                           cy_q <= cy_q + 8'd1;
                        end else begin
                           top_q    <= top_inc;
                           state_q  <= CLR_LINE;
                           busy_q   <= 1'b1;
                           col_q    <= '0;
                           wvalid_q <= 1'b1;
                           waddr_q  <= top_base;
                           wdata_q  <= SPACE;
                        end
                     end
                  end
               end
            end

            CLR_LINE: begin
               if (bus.mem_wready) begin
                  if (col_q == LAST_COL) begin
                     state_q  <= IDLE;
                     wvalid_q <= 1'b0;
                     busy_q   <= 1'b0;
                  end else begin
                     col_q   <= col_q + 8'd1;
                     waddr_q <= waddr_q + ADDR_BITS'(1);
                  end
               end
            end

            CLR_SCR: begin
               // First cycle after reset release: start the clear at addr 0.
               if (!wvalid_q) begin
                  wvalid_q <= 1'b1;
                  busy_q   <= 1'b1;
                  waddr_q  <= '0;
                  wdata_q  <= SPACE;
               end else if (bus.mem_wready) begin
                  if (waddr_q == LAST_ADDR) begin
                     state_q  <= IDLE;
                     wvalid_q <= 1'b0;
                     busy_q   <= 1'b0;
                  end else begin
                     waddr_q <= waddr_q + ADDR_BITS'(1);
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_tready  = (state_q == IDLE);
   assign bus.mem_wvalid = wvalid_q;
   assign bus.mem_waddr  = waddr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.top_row    = top_q;
   assign bus.cur_x      = cx_q;
   assign bus.cur_y      = cy_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_svo_term_writer.sv
// ---------------------------------------------------------------------------
// tb_svo_term_writer
// Directed bench for svo_term_writer (80x30). Expected RAM writes go into a
// queue as stimulus is issued; a negedge monitor pops and compares on every
// write handshake and checks that stalled writes hold their address/data.
// ---------------------------------------------------------------------------
module tb_svo_term_writer;
   localparam int unsigned COLS  = 80;
   localparam int unsigned ROWS  = 30;
   localparam int unsigned AW    = 12;
   localparam int          LIMIT = 20000;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic toggle_en = 1'b0;
   always #5 clk = ~clk;

   svo_term_writer_if #(.ADDR_BITS(AW)) bus ();

   svo_term_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_BITS(AW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0, failures = 0;
   int  exp_total = 0, wr_total = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void push(input int addr, input int data);
      wr_t e;
      e.addr = AW'(addr);
      e.data = 8'(data);
      exp_q.push_back(e);
      exp_total++;
   endfunction

   // Monitor: one comparison per handshake plus hold-stability after stalls.
   logic          stall_q = 1'b0;
   logic [AW-1:0] hold_a;
   logic [7:0]    hold_d;
   always @(negedge clk) begin
      if (!resetn) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("hold_valid", int'(bus.mem_wvalid), 1);
            check("hold_addr", int'(bus.mem_waddr), int'(hold_a));
            check("hold_data", int'(bus.mem_wdata), int'(hold_d));
         end
         if (bus.mem_wvalid && bus.mem_wready) begin
            wr_total++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: addr %0d data %0d with empty queue",
                        bus.mem_waddr, bus.mem_wdata);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("write_addr", int'(bus.mem_waddr), int'(e.addr));
               check("write_data", int'(bus.mem_wdata), int'(e.data));
            end
         end
         stall_q = bus.mem_wvalid && !bus.mem_wready;
         hold_a  = bus.mem_waddr;
         hold_d  = bus.mem_wdata;
      end
   end

   initial begin
      bus.mem_wready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (toggle_en) bus.mem_wready = ~bus.mem_wready;
         else           bus.mem_wready = 1'b1;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      bus.in_tvalid = 1'b1;
      bus.in_tdata  = b;
      forever begin
         @(negedge clk);
         if (bus.in_tready) break;
         n++;
         if (n > LIMIT) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte %0d not accepted", b);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_tvalid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.in_tready && !bus.busy && !bus.mem_wvalid && exp_q.size() == 0)
                 && n < LIMIT);
      check({name, "_done"}, int'(n < LIMIT), 1);
   endtask

   initial begin
      bus.in_tvalid = 1'b0;
      bus.in_tdata  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_wvalid", int'(bus.mem_wvalid), 0);
      check("rst_tready", int'(bus.in_tready), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_top", int'(bus.top_row), 0);
      check("rst_cx", int'(bus.cur_x), 0);
      check("rst_cy", int'(bus.cur_y), 0);
      check("rst_waddr", int'(bus.mem_waddr), 0);
      for (int i = 0; i < int'(COLS*ROWS); i++) push(i, 8'h20);
      resetn = 1'b1;
      wait_idle("init_clear");
      check("init_busy", int'(bus.busy), 0);
      check("init_tready", int'(bus.in_tready), 1);

      // "AB", backspace, CR, backspace at column 0, dropped control byte
      push(0, 8'h41);
      send_byte(8'h41);
      push(1, 8'h42);
      send_byte(8'h42);
      wait_idle("ab");
      check("ab_cx", int'(bus.cur_x), 2);
      push(1, 8'h20);
      send_byte(8'h08);
      wait_idle("bs");
      check("bs_cx", int'(bus.cur_x), 1);
      send_byte(8'h0D);
      check("cr_cx", int'(bus.cur_x), 0);
      send_byte(8'h08);
      send_byte(8'h01);
      wait_idle("noop");
      check("noop_cx", int'(bus.cur_x), 0);
      check("noop_cy", int'(bus.cur_y), 0);

      // 30 LFs: last one scrolls and clears old top physical row 0
      for (int i = 0; i < 29; i++) send_byte(8'h0A);
      check("lf29_cy", int'(bus.cur_y), 29);
      for (int i = 0; i < int'(COLS); i++) push(i, 8'h20);
      send_byte(8'h0A);
      check("lf30_top", int'(bus.top_row), 1);
      check("lf30_cy", int'(bus.cur_y), 29);
      check("lf30_cx", int'(bus.cur_x), 0);
      check("lf30_busy", int'(bus.busy), 1);

      // Stalling wready; 80 chars sent while the line clear is still running,
      // the last at (79,29) wraps, scrolls and clears physical row 1.
      toggle_en = 1'b1;
      for (int i = 0; i < int'(COLS); i++) begin
         push(i, 8'h41 + (i % 26));
         send_byte(8'(8'h41 + (i % 26)));
      end
      for (int i = 0; i < int'(COLS); i++) push(int'(COLS) + i, 8'h20);
      wait_idle("wrap");
      toggle_en = 1'b0;
      check("wrap_cx", int'(bus.cur_x), 0);
      check("wrap_cy", int'(bus.cur_y), 29);
      check("wrap_top", int'(bus.top_row), 2);

      // 28 more scrolls: top_row runs 2..29 and wraps to 0
      for (int t = 2; t < int'(ROWS); t++) begin
         for (int c = 0; c < int'(COLS); c++) push(t*int'(COLS) + c, 8'h20);
         send_byte(8'h0A);
      end
      wait_idle("topwrap");
      check("topwrap_top", int'(bus.top_row), 0);
      check("topwrap_cy", int'(bus.cur_y), 29);

      // Char at screen row 29 with top 0 lands in physical row 29
      push(29*int'(COLS), 8'h51);
      send_byte(8'h51);
      wait_idle("q");
      check("q_cx", int'(bus.cur_x), 1);

      // Form feed, then reset pulsed mid-clear: clear restarts at addr 0
      for (int i = 0; i < int'(COLS*ROWS); i++) push(i, 8'h20);
      send_byte(8'h0C);
      check("ff_cx", int'(bus.cur_x), 0);
      check("ff_top", int'(bus.top_row), 0);
      check("ff_busy", int'(bus.busy), 1);
      repeat (50) @(negedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      exp_total -= exp_q.size();
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("rst2_wvalid", int'(bus.mem_wvalid), 0);
      check("rst2_waddr", int'(bus.mem_waddr), 0);
      for (int i = 0; i < int'(COLS*ROWS); i++) push(i, 8'h20);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      wait_idle("rst2_clear");
      check("rst2_cx", int'(bus.cur_x), 0);
      check("rst2_cy", int'(bus.cur_y), 0);
      check("rst2_top", int'(bus.top_row), 0);

      check("queue_empty", exp_q.size(), 0);
      check("write_total", wr_total, exp_total);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
